// File: rtl/gray_ptr_conv_if.sv
// Pointer-side signal bundle for gray_ptr_conv: local pointer control,
// exported pointers, remote Gray input, level and error flag.
interface gray_ptr_conv_if #(
  parameter int WIDTH = 4
);
  logic             inc;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] ptr_bin;
  logic [WIDTH-1:0] ptr_gray;
  logic [WIDTH-1:0] gray_in;
  logic [WIDTH-1:0] remote_bin;
  logic [WIDTH-1:0] level;
  logic             gray_err;

  modport master (
    output inc, load, load_val, gray_in,
    input  ptr_bin, ptr_gray, remote_bin, level, gray_err
  );

  modport slave (
    input  inc, load, load_val, gray_in,
    output ptr_bin, ptr_gray, remote_bin, level, gray_err
  );
endinterface

// File: rtl/gray_ptr_conv.sv
// Gray-code pointer block for async FIFOs: local binary/Gray pointer, remote
// Gray-to-binary pipeline and registered level. Optional GRAY_PTR_CHECK_EN.
module gray_ptr_conv #(
  parameter int WIDTH = 4,
  parameter int PIPE  = 1
) (
  input  logic           clk,
  input  logic           rst,
  gray_ptr_conv_if.slave bus
);

  logic [WIDTH-1:0] ptr_bin_q, ptr_bin_d;
  logic [WIDTH-1:0] ptr_gray_q, ptr_gray_d;
  logic [WIDTH-1:0] remote_conv;
  logic [PIPE-1:0][WIDTH-1:0] pipe_q, pipe_d;
  logic [WIDTH-1:0] level_q, level_d;

  // Gray is derived from the next binary value so the exported copy is a flop
  always_comb begin
    ptr_bin_d = ptr_bin_q;
    if (bus.load) begin
      ptr_bin_d = bus.load_val;
    end else if (bus.inc) begin
      ptr_bin_d = ptr_bin_q + WIDTH'(1);
    end
    ptr_gray_d = ptr_bin_d ^ (ptr_bin_d >> 1);
  end

  // Each binary bit is the XOR of all Gray bits at or above it
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_conv
      assign remote_conv[gi] = ^(bus.gray_in >> gi);
    end
  endgenerate

  always_comb begin
    pipe_d[0] = remote_conv;
    for (int i = 1; i < PIPE; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    level_d = ptr_bin_q - pipe_q[PIPE-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_bin_q  <= '0;
      ptr_gray_q <= '0;
      pipe_q     <= '0;
      level_q    <= '0;
    end else begin
      ptr_bin_q  <= ptr_bin_d;
      ptr_gray_q <= ptr_gray_d;
      pipe_q     <= pipe_d;
      level_q    <= level_d;
    end
  end

  assign bus.ptr_bin    = ptr_bin_q;
  assign bus.ptr_gray   = ptr_gray_q;
  assign bus.remote_bin = pipe_q[PIPE-1];
  assign bus.level      = level_q;

`ifdef GRAY_PTR_CHECK_EN
  logic [WIDTH-1:0] cmp_q, cmp_d;
  logic [WIDTH-1:0] gray_diff;
  logic             chk_en_q, chk_en_d;
  logic             gray_err_q, gray_err_d;

  // diff & (diff-1) is nonzero exactly when more than one bit differs
  always_comb begin
    gray_diff  = bus.gray_in ^ cmp_q;
    cmp_d      = bus.gray_in;
    chk_en_d   = 1'b1;
    gray_err_d = gray_err_q |
                 (chk_en_q && ((gray_diff & (gray_diff - WIDTH'(1))) != '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q      <= '0;
      chk_en_q   <= 1'b0;
      gray_err_q <= 1'b0;
    end else begin
      cmp_q      <= cmp_d;
      chk_en_q   <= chk_en_d;
      gray_err_q <= gray_err_d;
    end
  end

  assign bus.gray_err = gray_err_q;
`else
  assign bus.gray_err = 1'b0;
`endif

endmodule

// File: doc/gray_ptr_conv.md
# gray_ptr_conv

Parametrised Gray-code pointer block for clock-domain-crossing FIFOs. It holds a local binary pointer with a registered, glitch-free Gray copy for export to the other domain. It also converts a remote, already-synchronised Gray pointer back to binary through a configurable pipeline. From the two pointers it produces a registered modulo difference (fill/space level). It sits at each side of an asynchronous FIFO, between the pointer synchroniser and the full/empty logic.

## Interface
Parameters:
- WIDTH, 4, pointer width in bits (2..16); pointer space is 2^WIDTH.
- PIPE, 1, register stages after remote Gray-to-binary conversion (1..4).

Ports:
- clk  in  1  single clock; all registers on rising edge.
- rst  in  1  reset, synchronous, active-high.
- inc  in  1  advance local pointer by one.
- load  in  1  load local pointer from load_val.
- load_val  in  WIDTH  binary load value.
- ptr_bin  out  WIDTH  local pointer, binary, registered.
- ptr_gray  out  WIDTH  local pointer, Gray, registered (exported across domains).
- gray_in  in  WIDTH  remote pointer, Gray, already synchronised into clk.
- remote_bin  out  WIDTH  gray_in converted to binary, PIPE cycles late.
- level  out  WIDTH  (ptr_bin − remote_bin) mod 2^WIDTH, registered.
- gray_err  out  1  sticky multi-bit-change flag (see Configuration).

## Operation
- Local pointer priority, highest first: rst, load, inc, hold.
- On inc, next_bin = ptr_bin + 1 mod 2^WIDTH. The value wraps from 2^WIDTH−1 to 0 with no flag.
- ptr_gray is registered on the same edge as ptr_bin, from next_bin ^ (next_bin >> 1). It must never be decoded combinationally from ptr_bin at the output, so each ptr_gray transition flips exactly one bit on inc.
- If load and inc are both high, load wins and inc is ignored that cycle.
- Remote conversion:
  - bin[WIDTH−1] = gray[WIDTH−1].
  - bin[i] = bin[i+1] ^ gray[i], for i from WIDTH−2 down to 0.
  - This is performed combinationally on gray_in, then passed through PIPE register stages to remote_bin.
- level is computed from the current ptr_bin and remote_bin registers, with unsigned WIDTH-bit subtraction truncated (modulo) and then registered.

## Timing
- Reset values (the cycle after rst is sampled high): ptr_bin=0, ptr_gray=0, all remote pipeline stages=0, remote_bin=0, level=0, gray_err=0.
- rst asserted mid-operation overrides load/inc on that edge. Pipeline contents are discarded, not drained.
- inc/load latency: one cycle, ptr_bin and ptr_gray updating together.
- gray_in to remote_bin latency: PIPE cycles.
  - A value sampled at edge k appears after edge k+PIPE−1.
  - PIPE=1 means visible after the same edge that samples it.
- ptr_bin/remote_bin change to level latency: one further cycle.
- Each pipeline stage accepts a new value every cycle. There is no backpressure and no valid signal.

## Configuration
- Macro GRAY_PTR_CHECK_EN.
- Defined:
  - gray_in is registered into a compare register each cycle.
  - If popcount(gray_in ^ previous) > 1, gray_err sets on the next edge and stays set until rst.
  - The check is suppressed on the first cycle after reset release.
- Undefined: gray_err is tied to 0, and no compare logic or register exists.

## Test plan
- Reset then 16 inc pulses, WIDTH=4:
  - ptr_gray steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then wraps to 0 with ptr_bin=0.
  - Exactly one ptr_gray bit changes per step.
- load=1, load_val=4'hA (with inc=1 in the same cycle) → next cycle ptr_bin=4'hA, ptr_gray=4'hF; inc has no effect.
- PIPE=3, gray_in steps 0 → 4'hC at edge k → remote_bin=4'h8 first visible after edge k+2, 0 before.
- Level wrap: ptr_bin=3 and remote_bin=13 stable → level=6 one cycle later. With ptr_bin=remote_bin → level=0.
- Gray error check:
  - Macro defined: gray_in 0→1→3 gives gray_err=0. A later 3→4 (3 bits) sets gray_err=1 on the next edge; it stays 1 through further valid changes until rst.
  - Macro undefined: gray_err=0 throughout.
- Mid-run reset: after 5 incs with a nonzero remote pipeline, assert rst for one cycle → all outputs 0 the next cycle. An inc after release gives ptr_gray=1.
